// File: rtl/memory_arbiter_if.sv
// Read-request bundle shared by cache clients and memory: enable/address
// flow from requester to responder, valid/data flow back.
interface memory_arbiter_if;
   logic        address_enable;
   logic [31:0] address;
   logic        data_valid;
   logic [31:0] data;

   modport master (output address_enable, address, input data_valid, data);
   modport slave  (input address_enable, address, output data_valid, data);
endinterface

// File: rtl/memory_arbiter.sv
// Round-robin arbiter sharing one memory read port between two cache fill
// clients, with a watchdog that abandons transactions memory never answers.
module memory_arbiter #(
   parameter int TIMEOUT = 255,
   parameter int CW      = 8
) (
   input  logic             clock,
   input  logic             reset_n,
   memory_arbiter_if.slave  a,
   memory_arbiter_if.slave  b,
   memory_arbiter_if.master mem,
   output logic             busy,
   output logic             timeout_error
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SERVE_A = 2'd1,
      SERVE_B = 2'd2
   } state_t;

   state_t        state;
   logic          last_grant;      // 1 = B was granted last
   logic [CW-1:0] wd;
   logic [31:0]   grant_address;

   logic serving_b;
   logic own_enable;
   logic other_enable;
   logic expired;

   always_comb begin
      serving_b    = (state == SERVE_B);
      own_enable   = serving_b ? b.address_enable : a.address_enable;
      other_enable = serving_b ? a.address_enable : b.address_enable;
      expired      = (wd == CW'(TIMEOUT - 1));
   end

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         wd            <= '0;
         timeout_error <= 1'b0;
         grant_address <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (a.address_enable && (!b.address_enable || last_grant)) begin
                  state         <= SERVE_A;
                  last_grant    <= 1'b0;
                  wd            <= '0;
                  grant_address <= a.address;
               end else if (b.address_enable) begin
                  state         <= SERVE_B;
                  last_grant    <= 1'b1;
                  wd            <= '0;
                  grant_address <= b.address;
               end
            end
            SERVE_A, SERVE_B: begin
               if (!own_enable) begin
                  state <= IDLE;
               end else if (mem.data_valid) begin
                  // Hand straight over to a waiting peer to avoid an idle bubble.
                  if (other_enable) begin
                     state         <= serving_b ? SERVE_A : SERVE_B;
                     last_grant    <= !serving_b;
                     wd            <= '0;
                     grant_address <= serving_b ? a.address : b.address;
                  end else begin
                     state <= IDLE;
                  end
               end else if (expired) begin
                  state         <= IDLE;
                  timeout_error <= 1'b1;
               end else begin
                  wd <= wd + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign busy               = (state != IDLE);
   assign mem.address_enable = busy && own_enable;
   assign mem.address        = busy ? grant_address : '0;

   assign a.data_valid = (state == SERVE_A) && a.address_enable && mem.data_valid;
   assign b.data_valid = (state == SERVE_B) && b.address_enable && mem.data_valid;
   assign a.data       = mem.data;
   assign b.data       = mem.data;

endmodule

// File: tb/tb_memory_arbiter.sv
// Directed and randomized checks of memory_arbiter against a transaction-level
// model of who owns the memory port each cycle.
module tb_memory_arbiter;
   localparam int TIMEOUT = 4;

   logic clock = 1'b0;
   logic reset_n;
   logic busy;
   logic timeout_error;

   memory_arbiter_if a_if ();
   memory_arbiter_if b_if ();
   memory_arbiter_if mem_if ();

   memory_arbiter #(.TIMEOUT(TIMEOUT), .CW(8)) dut (
      .clock         (clock),
      .reset_n       (reset_n),
      .a             (a_if),
      .b             (b_if),
      .mem           (mem_if),
      .busy          (busy),
      .timeout_error (timeout_error)
   );

   always #5 clock = ~clock;

   int tests = 0;
   int fails = 0;

   // Model: owner 0 = nobody, 1 = A, 2 = B.
   int owner;
   int last_owner;
   int waited;
   bit err_seen;
   bit exp_adv_last;
   bit exp_bdv_last;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      tests++;
      assert (observed === expected)
      else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, observed, expected);
      end
   endtask

   task automatic model_reset();
      owner      = 0;
      last_owner = 2;
      waited     = 0;
      err_seen   = 1'b0;
   endtask

   // One clock cycle: predict outputs from the current inputs, compare at the
   // falling edge, then advance the model across the rising edge.
   task automatic cycle();
      bit          a_en, b_en, dv, own_en, other_en;
      bit          e_mae, e_adv, e_bdv;
      logic [31:0] e_addr;
      a_en   = a_if.address_enable;
      b_en   = b_if.address_enable;
      dv     = mem_if.data_valid;
      e_mae  = (owner == 1) ? a_en : (owner == 2) ? b_en : 1'b0;
      e_addr = (owner == 1) ? a_if.address : (owner == 2) ? b_if.address : 32'h0;
      e_adv  = (owner == 1) && a_en && dv;
      e_bdv  = (owner == 2) && b_en && dv;
      @(negedge clock);
      check("mem_address_enable", mem_if.address_enable, e_mae);
      check("mem_address", mem_if.address, e_addr);
      check("a_data_valid", a_if.data_valid, e_adv);
      check("b_data_valid", b_if.data_valid, e_bdv);
      check("busy", busy, owner != 0);
      check("timeout_error", timeout_error, err_seen);
      check("a_data", a_if.data, mem_if.data);
      check("b_data", b_if.data, mem_if.data);
      exp_adv_last = e_adv;
      exp_bdv_last = e_bdv;
      if (owner == 0) begin
         if (a_en && b_en) owner = (last_owner == 1) ? 2 : 1;
         else if (a_en)    owner = 1;
         else if (b_en)    owner = 2;
         if (owner != 0) begin
            last_owner = owner;
            waited     = 0;
         end
      end else begin
         own_en   = (owner == 1) ? a_en : b_en;
         other_en = (owner == 1) ? b_en : a_en;
         if (!own_en) begin
            owner = 0;
         end else if (dv) begin
            if (other_en) begin
               owner      = 3 - owner;
               last_owner = owner;
               waited     = 0;
            end else begin
               owner = 0;
            end
         end else begin
            waited++;
            if (waited == TIMEOUT) begin
               owner    = 0;
               err_seen = 1'b1;
            end
         end
      end
      @(posedge clock);
      #1;
   endtask

   task automatic do_reset();
      reset_n = 1'b0;
      #2;
      reset_n = 1'b1;
      model_reset();
      @(posedge clock);
      #1;
   endtask

   initial begin
      reset_n                = 1'b0;
      a_if.address_enable    = 1'b0;
      a_if.address           = '0;
      b_if.address_enable    = 1'b0;
      b_if.address           = '0;
      mem_if.data_valid      = 1'b0;
      mem_if.data            = '0;
      model_reset();

      // Reset state
      #12;
      check("rst_busy", busy, 1'b0);
      check("rst_mae", mem_if.address_enable, 1'b0);
      check("rst_maddr", mem_if.address, 32'h0);
      check("rst_err", timeout_error, 1'b0);
      check("rst_adv", a_if.data_valid, 1'b0);
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;

      // Single A request, memory answers 3 cycles after enable
      a_if.address        = 32'h0000_0040;
      a_if.address_enable = 1'b1;
      cycle();
      check("t1_mae", mem_if.address_enable, 1'b1);
      check("t1_maddr", mem_if.address, 32'h40);
      repeat (3) cycle();
      mem_if.data_valid = 1'b1;
      mem_if.data       = 32'hDEAD_BEEF;
      #1;
      check("t1_adv", a_if.data_valid, 1'b1);
      check("t1_adata", a_if.data, 32'hDEAD_BEEF);
      check("t1_bdv", b_if.data_valid, 1'b0);
      cycle();
      a_if.address_enable = 1'b0;
      mem_if.data_valid   = 1'b0;
      check("t1_idle", busy, 1'b0);
      cycle();

      // Simultaneous requests after reset: A first, B without a bubble
      do_reset();
      a_if.address        = 32'h100;
      b_if.address        = 32'h200;
      a_if.address_enable = 1'b1;
      b_if.address_enable = 1'b1;
      cycle();
      check("t2_first", mem_if.address, 32'h100);
      mem_if.data_valid = 1'b1;
      mem_if.data       = 32'h1111_0000;
      #1;
      check("t2_adv", a_if.data_valid, 1'b1);
      cycle();
      a_if.address_enable = 1'b0;
      mem_if.data_valid   = 1'b0;
      check("t2_switch", mem_if.address, 32'h200);
      check("t2_mae", mem_if.address_enable, 1'b1);
      cycle();
      mem_if.data_valid = 1'b1;
      mem_if.data       = 32'h2222_0000;
      #1;
      check("t2_bdv", b_if.data_valid, 1'b1);
      cycle();
      b_if.address_enable = 1'b0;
      mem_if.data_valid   = 1'b0;

      // Both hold requests: grants alternate A, B, A, B, A, B
      a_if.address_enable = 1'b1;
      b_if.address_enable = 1'b1;
      mem_if.data_valid   = 1'b1;
      cycle();
      for (int i = 0; i < 6; i++) begin
         check("t3_adv", a_if.data_valid, (i % 2) == 0);
         check("t3_bdv", b_if.data_valid, (i % 2) == 1);
         cycle();
      end
      a_if.address_enable = 1'b0;
      b_if.address_enable = 1'b0;
      mem_if.data_valid   = 1'b0;
      cycle();

      // A aborts two cycles into service, memory answers one cycle later
      a_if.address        = 32'h400;
      a_if.address_enable = 1'b1;
      cycle();
      repeat (2) cycle();
      a_if.address_enable = 1'b0;
      cycle();
      mem_if.data_valid = 1'b1;
      #1;
      check("t4_adv", a_if.data_valid, 1'b0);
      check("t4_bdv", b_if.data_valid, 1'b0);
      check("t4_idle", busy, 1'b0);
      cycle();
      mem_if.data_valid = 1'b0;

      // Abort and data valid in the same cycle
      a_if.address_enable = 1'b1;
      cycle();
      a_if.address_enable = 1'b0;
      mem_if.data_valid   = 1'b1;
      #1;
      check("t4b_adv", a_if.data_valid, 1'b0);
      cycle();
      check("t4b_idle", busy, 1'b0);
      mem_if.data_valid = 1'b0;

      // Data valid on the last watchdog cycle wins over expiry
      do_reset();
      b_if.address        = 32'h300;
      b_if.address_enable = 1'b1;
      cycle();
      repeat (TIMEOUT - 1) cycle();
      mem_if.data_valid = 1'b1;
      #1;
      check("t5a_bdv", b_if.data_valid, 1'b1);
      cycle();
      check("t5a_err", timeout_error, 1'b0);
      b_if.address_enable = 1'b0;
      mem_if.data_valid   = 1'b0;
      cycle();

      // Memory never answers B: watchdog abandons, B is re-granted
      b_if.address_enable = 1'b1;
      cycle();
      repeat (TIMEOUT) cycle();
      check("t5_idle", busy, 1'b0);
      check("t5_err", timeout_error, 1'b1);
      cycle();
      check("t5_regrant", mem_if.address_enable, 1'b1);
      check("t5_raddr", mem_if.address, 32'h300);
      mem_if.data_valid = 1'b1;
      #1;
      check("t5_bdv", b_if.data_valid, 1'b1);
      cycle();
      b_if.address_enable = 1'b0;
      mem_if.data_valid   = 1'b0;
      check("t5_sticky", timeout_error, 1'b1);
      cycle();

      // Asynchronous reset in the middle of SERVE_A
      do_reset();
      a_if.address_enable = 1'b1;
      cycle();
      cycle();
      mem_if.data_valid = 1'b1;
      #2;
      reset_n = 1'b0;
      #1;
      check("t6_busy", busy, 1'b0);
      check("t6_mae", mem_if.address_enable, 1'b0);
      check("t6_maddr", mem_if.address, 32'h0);
      check("t6_adv", a_if.data_valid, 1'b0);
      model_reset();
      a_if.address_enable = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
      @(posedge clock);
      #1;
      check("t6_late_adv", a_if.data_valid, 1'b0);
      cycle();
      mem_if.data_valid = 1'b0;
      cycle();

      // Randomized traffic against the model, including watchdog expiries
      do_reset();
      for (int n = 0; n < 600; n++) begin
         if (!a_if.address_enable && ($urandom % 3 == 0)) begin
            a_if.address_enable = 1'b1;
            a_if.address        = $urandom;
         end
         if (!b_if.address_enable && ($urandom % 3 == 0)) begin
            b_if.address_enable = 1'b1;
            b_if.address        = $urandom;
         end
         mem_if.data_valid = ($urandom % 3 == 0);
         mem_if.data       = $urandom;
         cycle();
         if (exp_adv_last) a_if.address_enable = 1'b0;
         if (exp_bdv_last) b_if.address_enable = 1'b0;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
